// File: rtl/i2c_pkg.sv
// Shared definitions for the WM8731 control-port responder.
//  - DEV_ADDR_DEFAULT : 7-bit target address of the codec (write byte 8'h34)
//  - REG_*            : WM8731 register indices as seen in the frame
//  - i2c_rx_state_t   : receive FSM states
//  - frame_open()     : 1 in states where a frame has started past the address
//                       byte but has not yet reached ACK_LO
package i2c_pkg;

  localparam logic [6:0] DEV_ADDR_DEFAULT = 7'h1A;

  localparam logic [6:0] REG_LEFT_LINE_IN  = 7'h00;
  localparam logic [6:0] REG_RIGHT_LINE_IN = 7'h01;
  localparam logic [6:0] REG_LEFT_HP_OUT   = 7'h02;
  localparam logic [6:0] REG_RIGHT_HP_OUT  = 7'h03;
  localparam logic [6:0] REG_ANALOG_PATH   = 7'h04;
  localparam logic [6:0] REG_DIGITAL_PATH  = 7'h05;
  localparam logic [6:0] REG_POWER_DOWN    = 7'h06;
  localparam logic [6:0] REG_DIGITAL_IF    = 7'h07;
  localparam logic [6:0] REG_SAMPLING      = 7'h08;
  localparam logic [6:0] REG_ACTIVE        = 7'h09;
  localparam logic [6:0] REG_RESET         = 7'h0F;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_ADDR      = 3'd1,
    ST_ACK_ADDR  = 3'd2,
    ST_BYTE_HI   = 3'd3,
    ST_ACK_HI    = 3'd4,
    ST_BYTE_LO   = 3'd5,
    ST_ACK_LO    = 3'd6,
    ST_WAIT_STOP = 3'd7
  } i2c_rx_state_t;

  // A STOP or START seen in one of these states truncates a frame.
  function automatic logic frame_open(input i2c_rx_state_t st);
    case (st)
      ST_ACK_ADDR, ST_BYTE_HI, ST_ACK_HI, ST_BYTE_LO: frame_open = 1'b1;
      default:                                        frame_open = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/i2c_bus_sync.sv
// Bus front end: synchronizes SCL/SDA into the system clock domain and
// derives single-cycle event strobes from the synchronized samples.
// Ports:
//  clk_i, rst_i     system clock, asynchronous active-high reset
//  scl_i, sda_i     raw bus lines
//  sda_o            synchronized SDA level (bit value on SCL rise)
//  scl_rise_o       SCL 0->1
//  scl_fall_o       SCL 1->0
//  start_o          SDA 1->0 while SCL stays high
//  stop_o           SDA 0->1 while SCL stays high
// SYNC_STAGES must be >= 2.
module i2c_bus_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic scl_i,
  input  logic sda_i,
  output logic sda_o,
  output logic scl_rise_o,
  output logic scl_fall_o,
  output logic start_o,
  output logic stop_o
);

  logic [SYNC_STAGES-1:0] scl_sync_q;
  logic [SYNC_STAGES-1:0] sda_sync_q;
  logic                   scl_prev_q;
  logic                   sda_prev_q;
  logic                   scl_s;
  logic                   sda_s;

  // Synchronizer chains plus one history stage; reset to the idle bus level
  // so that leaving reset on an idle bus produces no spurious events.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      scl_sync_q <= {SYNC_STAGES{1'b1}};
      sda_sync_q <= {SYNC_STAGES{1'b1}};
      scl_prev_q <= 1'b1;
      sda_prev_q <= 1'b1;
    end else begin
      scl_sync_q <= {scl_sync_q[SYNC_STAGES-2:0], scl_i};
      sda_sync_q <= {sda_sync_q[SYNC_STAGES-2:0], sda_i};
      scl_prev_q <= scl_s;
      sda_prev_q <= sda_s;
    end
  end

  assign scl_s = scl_sync_q[SYNC_STAGES-1];
  assign sda_s = sda_sync_q[SYNC_STAGES-1];

  assign sda_o      = sda_s;
  assign scl_rise_o = scl_s & ~scl_prev_q;
  assign scl_fall_o = ~scl_s & scl_prev_q;
  // SCL must be high in both samples so an SDA change that coincides
  // with an SCL edge is not mistaken for a bus condition.
  assign start_o    = scl_s & scl_prev_q & sda_prev_q & ~sda_s;
  assign stop_o     = scl_s & scl_prev_q & ~sda_prev_q & sda_s;

endmodule

// File: rtl/i2c_codec_responder.sv
// I2C target model of the WM8731 control port. ACKs 3-byte write frames
// {DEV_ADDR+W, {reg[6:0], d[8]}, d[7:0]} and mirrors every decoded write
// into a shadow register file.
// Ports:
//  i_clk, i_rst  system clock, asynchronous active-high reset
//  i_sclk        SCL as seen on the bus
//  i_sdat        resolved SDA bus value
//  o_sdat_oe     1 = pull SDA low (ACK)
//  o_busy        1 between START and STOP
//  o_wr_valid    one-cycle pulse per decoded register write
//  o_wr_addr     register address of the last write
//  o_wr_data     register data of the last write
//  o_err         one-cycle pulse: truncated frame or out-of-range register
//  o_wr_cnt      completed writes, saturating at 255
//  i_rd_addr     shadow register read index
//  o_rd_data     shadow register content (combinational)
module i2c_codec_responder
  import i2c_pkg::*;
#(
  parameter logic [6:0] DEV_ADDR    = DEV_ADDR_DEFAULT,
  parameter int         NUM_REGS    = 16,
  parameter int         SYNC_STAGES = 2
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_sclk,
  input  logic       i_sdat,
  output logic       o_sdat_oe,
  output logic       o_busy,
  output logic       o_wr_valid,
  output logic [6:0] o_wr_addr,
  output logic [8:0] o_wr_data,
  output logic       o_err,
  output logic [7:0] o_wr_cnt,
  input  logic [3:0] i_rd_addr,
  output logic [8:0] o_rd_data
);

  logic sda_s;
  logic scl_rise_s;
  logic scl_fall_s;
  logic start_s;
  logic stop_s;

  i2c_bus_sync #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_bus_sync (
    .clk_i      (i_clk),
    .rst_i      (i_rst),
    .scl_i      (i_sclk),
    .sda_i      (i_sdat),
    .sda_o      (sda_s),
    .scl_rise_o (scl_rise_s),
    .scl_fall_o (scl_fall_s),
    .start_o    (start_s),
    .stop_o     (stop_s)
  );

  i2c_rx_state_t state_q;
  logic [7:0]    shift_q;
  logic [3:0]    bit_cnt_q;
  logic [7:0]    hi_q;
  logic          oe_q;
  logic          busy_q;
  logic          wr_valid_q;
  logic [6:0]    wr_addr_q;
  logic [8:0]    wr_data_q;
  logic          err_q;
  logic [7:0]    wr_cnt_q;
  logic [8:0]    shadow_q [0:NUM_REGS-1];

  logic bit_take_s;
  logic byte_done_s;
  logic reg_in_range_s;

  // Bits 1..8 are taken on SCL rises; the 9th rise belongs to the ACK slot.
  assign bit_take_s     = scl_rise_s && (bit_cnt_q != 4'd8);
  // The byte is handed over on the falling edge that ends its 8th bit, so
  // the ACK drive starts while SCL is low.
  assign byte_done_s    = scl_fall_s && (bit_cnt_q == 4'd8);
  assign reg_in_range_s = ({25'd0, hi_q[7:1]} < 32'(NUM_REGS));

  // Receive FSM with its datapath, registered outputs and shadow registers.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q    <= ST_IDLE;
      shift_q    <= 8'd0;
      bit_cnt_q  <= 4'd0;
      hi_q       <= 8'd0;
      oe_q       <= 1'b0;
      busy_q     <= 1'b0;
      wr_valid_q <= 1'b0;
      wr_addr_q  <= 7'd0;
      wr_data_q  <= 9'd0;
      err_q      <= 1'b0;
      wr_cnt_q   <= 8'd0;
      for (int i = 0; i < NUM_REGS; i++) begin
        shadow_q[i] <= 9'd0;
      end
    end else begin
      wr_valid_q <= 1'b0;
      err_q      <= 1'b0;
      if (start_s) begin
        // START (first or repeated) always restarts address reception.
        err_q     <= frame_open(state_q);
        state_q   <= ST_ADDR;
        bit_cnt_q <= 4'd0;
        oe_q      <= 1'b0;
        busy_q    <= 1'b1;
      end else if (stop_s) begin
        err_q     <= frame_open(state_q);
        state_q   <= ST_IDLE;
        bit_cnt_q <= 4'd0;
        oe_q      <= 1'b0;
        busy_q    <= 1'b0;
      end else begin
        case (state_q)
          ST_IDLE: begin
            oe_q <= 1'b0;
          end
          ST_ADDR: begin
            if (bit_take_s) begin
              shift_q   <= {shift_q[6:0], sda_s};
              bit_cnt_q <= bit_cnt_q + 4'd1;
            end else if (byte_done_s) begin
              bit_cnt_q <= 4'd0;
              if (shift_q == {DEV_ADDR, 1'b0}) begin
                state_q <= ST_ACK_ADDR;
                oe_q    <= 1'b1;
              end else begin
                state_q <= ST_WAIT_STOP;
              end
            end
          end
          ST_BYTE_HI: begin
            if (bit_take_s) begin
              shift_q   <= {shift_q[6:0], sda_s};
              bit_cnt_q <= bit_cnt_q + 4'd1;
            end else if (byte_done_s) begin
              bit_cnt_q <= 4'd0;
              hi_q      <= shift_q;
              state_q   <= ST_ACK_HI;
              oe_q      <= 1'b1;
            end
          end
          ST_BYTE_LO: begin
            if (bit_take_s) begin
              shift_q   <= {shift_q[6:0], sda_s};
              bit_cnt_q <= bit_cnt_q + 4'd1;
            end else if (byte_done_s) begin
              bit_cnt_q  <= 4'd0;
              state_q    <= ST_ACK_LO;
              oe_q       <= 1'b1;
              wr_valid_q <= 1'b1;
              wr_addr_q  <= hi_q[7:1];
              wr_data_q  <= {hi_q[0], shift_q};
              if (wr_cnt_q != 8'hFF) begin
                wr_cnt_q <= wr_cnt_q + 8'd1;
              end
              // Out-of-range writes are still ACKed, only flagged.
              if (reg_in_range_s) begin
                for (int i = 0; i < NUM_REGS; i++) begin
                  if (hi_q[7:1] == 7'(i)) begin
                    shadow_q[i] <= {hi_q[0], shift_q};
                  end
                end
              end else begin
                err_q <= 1'b1;
              end
            end
          end
          // The falling edge after the master's 9th rise ends the ACK slot.
          ST_ACK_ADDR: begin
            if (scl_fall_s) begin
              state_q <= ST_BYTE_HI;
              oe_q    <= 1'b0;
            end
          end
          ST_ACK_HI: begin
            if (scl_fall_s) begin
              state_q <= ST_BYTE_LO;
              oe_q    <= 1'b0;
            end
          end
          // Any further data byte after a full frame goes unacknowledged.
          ST_ACK_LO: begin
            if (scl_fall_s) begin
              state_q <= ST_WAIT_STOP;
              oe_q    <= 1'b0;
            end
          end
          ST_WAIT_STOP: begin
            oe_q <= 1'b0;
          end
          default: begin
            state_q <= ST_IDLE;
            oe_q    <= 1'b0;
          end
        endcase
      end
    end
  end

  assign o_sdat_oe  = oe_q;
  assign o_busy     = busy_q;
  assign o_wr_valid = wr_valid_q;
  assign o_wr_addr  = wr_addr_q;
  assign o_wr_data  = wr_data_q;
  assign o_err      = err_q;
  assign o_wr_cnt   = wr_cnt_q;

  // Read port sees the registered array, so a same-cycle write shows next cycle.
  assign o_rd_data = ({28'd0, i_rd_addr} < 32'(NUM_REGS)) ? shadow_q[i_rd_addr] : 9'd0;

endmodule
